agg_oq_merge: RTL and testbench
===============================

# agg_oq_merge

Packet-granular two-input AXI-Stream merger that recombines the aggregator result stream and the bypass (output-queue) stream into one stream toward the output queues. It is the return-path counterpart of the parser split. It arbitrates round-robin at packet boundaries, never interleaves beats of different packets, and registers the output through a one-entry pipeline stage. Per-source packet counters are exported for status.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master tdata width
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width (must equal master)
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width (must equal master)
- axis_aclk  in  1  single clock, all logic rising-edge
- axis_resetn  in  1  asynchronous, active-low reset
- s_axis_agg_tdata / tkeep / tuser / tvalid / tlast  in  256/32/128/1/1  aggregator result stream
- s_axis_agg_tready  out  1  ready to aggregator
- s_axis_OQ_tdata / tkeep / tuser / tvalid / tlast  in  256/32/128/1/1  bypass stream
- s_axis_OQ_tready  out  1  ready to bypass source
- m_axis_tdata / tkeep / tuser / tlast  out  256/32/128/1  merged stream (registered)
- m_axis_tvalid  out  1  merged valid (registered)
- m_axis_tready  in  1  downstream ready
- pkt_count_agg  out  32  packets accepted from agg port
- pkt_count_OQ  out  32  packets accepted from OQ port

## Operation
- States: IDLE, SEND_AGG, SEND_OQ.
- IDLE: both s_*_tready = 0. If exactly one tvalid is high, the next state is that port's SEND state. If both are high, the grant goes to the port not in last_grant. If neither is high, stay in IDLE. last_grant updates on each grant.
- SEND_x: only the granted port's tready may be high. tready_x = ~out_valid | m_axis_tready. The other port's tready = 0.
- Beat accept = tvalid_x & tready_x. An accepted beat loads the output register with tdata, tkeep, tuser and tlast unmodified, and sets out_valid.
- Accepted beat with tlast = 1: pkt_count_x += 1 and the next state is IDLE.
- Output register: when m_axis_tready & out_valid and no load occurs in that cycle, clear out_valid. A simultaneous drain and load keeps out_valid = 1 with the new beat.
- Counters are 32-bit and wrap 0xFFFFFFFF → 0. They are never saturated or cleared except by reset.
- Reset values: state = IDLE, last_grant = OQ (so the first tie goes to agg), m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata/tkeep/tuser = 0, both s_*_tready = 0, both counters = 0.
- Reset asserted mid-packet: all state clears immediately. Any buffered beat is discarded and the packet is truncated; recovery is the upstream's responsibility. After reset deasserts, the block starts again in IDLE.
- A single-beat packet (tvalid & tlast on the first beat) is legal. It enters SEND_x, transfers one beat, then returns to IDLE.
- tvalid deasserting mid-packet on the granted port keeps the grant (no switch until tlast).

## Timing
- Arbitration costs one cycle per packet. If tvalid is seen in IDLE at cycle N, the first beat is accepted at N+1 and appears on m_axis at N+2.
- Data latency is 1 cycle, from input accept to m_axis_tvalid.
- Steady state within a packet is 1 beat/cycle while m_axis_tready = 1.
- Minimum gap is one idle cycle on the input between the tlast accept and the next packet's first accept. The output shows no bubble only if the downstream stalls.
- m_axis_* stay stable while m_axis_tvalid & ~m_axis_tready.
- A counter updates on the edge following the tlast accept.

## Test plan
- Agg-only: a 3-beat packet on agg with m_axis_tready = 1 → m_axis shows 3 beats at cycles 2, 3, 4 with identical data; tlast on beat 3; pkt_count_agg = 1; s_axis_OQ_tready stays 0.
- Tie after reset: a 2-beat packet on agg and a 2-beat packet on OQ, both valid at cycle 0 → agg is forwarded first, then OQ; no interleaving; both counters = 1.
- Round-robin: continuous single-beat packets on both ports for 8 packets → output source alternates agg, OQ, agg, …; each counter = 4.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat OQ packet → no beat is lost or duplicated; outputs hold while stalled; s_axis_OQ_tready = 0 whenever out_valid & ~m_axis_tready.
- Reset mid-packet: assert axis_resetn = 0 asynchronously at beat 2 of 4 → m_axis_tvalid drops without waiting for a clock edge; counters = 0; the next packet after release is forwarded cleanly from IDLE.
- Counter wrap: force pkt_count_agg to 0xFFFFFFFF, then send one agg packet → counter reads 0.

Source files
------------

// File: rtl/agg_oq_merge.sv
// agg_oq_merge: packet-granular round-robin merge of the aggregator and bypass streams into one registered AXI-Stream output
module agg_oq_merge #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_agg_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_agg_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_agg_tuser,
  input  logic                                 s_axis_agg_tvalid,
  input  logic                                 s_axis_agg_tlast,
  output logic                                 s_axis_agg_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_OQ_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_OQ_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_OQ_tuser,
  input  logic                                 s_axis_OQ_tvalid,
  input  logic                                 s_axis_OQ_tlast,
  output logic                                 s_axis_OQ_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tlast,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [31:0]                          pkt_count_agg,
  output logic [31:0]                          pkt_count_OQ
);
  typedef enum logic [1:0] {IDLE, SEND_AGG, SEND_OQ} state_t;
  state_t state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic out_valid_q;
  logic [C_M_AXIS_DATA_WIDTH-1:0] tdata_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] tkeep_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_q;
  logic tlast_q;
  logic [31:0] cnt_agg_q, cnt_oq_q;
  logic acc_agg, acc_oq, load;
  assign acc_agg = s_axis_agg_tvalid & s_axis_agg_tready;
  assign acc_oq  = s_axis_OQ_tvalid & s_axis_OQ_tready;
  assign load    = acc_agg | acc_oq;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = out_valid_q;
  assign pkt_count_agg = cnt_agg_q;
  assign pkt_count_OQ  = cnt_oq_q;
  // state and grant history; last_grant_q = 1 means OQ was granted last
  always_ff @(posedge axis_aclk or negedge axis_resetn)
    if (!axis_resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  // arbitrate in IDLE, hold the grant until the granted port's tlast is accepted
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (s_axis_agg_tvalid & (~s_axis_OQ_tvalid | last_grant_q)) begin
        state_d      = SEND_AGG;
        last_grant_d = 1'b0;
      end else if (s_axis_OQ_tvalid) begin
        state_d      = SEND_OQ;
        last_grant_d = 1'b1;
      end
    end else if ((acc_agg & s_axis_agg_tlast) | (acc_oq & s_axis_OQ_tlast)) begin
      state_d = IDLE;
    end
  end
  // only the granted port may be ready, and only when the output slot is free or draining
  always_comb begin
    s_axis_agg_tready = (state_q == SEND_AGG) & (~out_valid_q | m_axis_tready);
    s_axis_OQ_tready  = (state_q == SEND_OQ)  & (~out_valid_q | m_axis_tready);
  end
  // one-entry output stage: load on accept, otherwise drain when downstream takes it
  always_ff @(posedge axis_aclk or negedge axis_resetn)
    if (!axis_resetn) begin
      out_valid_q <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      tdata_q     <= acc_agg ? s_axis_agg_tdata : s_axis_OQ_tdata;
      tkeep_q     <= acc_agg ? s_axis_agg_tkeep : s_axis_OQ_tkeep;
      tuser_q     <= acc_agg ? s_axis_agg_tuser : s_axis_OQ_tuser;
      tlast_q     <= acc_agg ? s_axis_agg_tlast : s_axis_OQ_tlast;
    end else if (m_axis_tready) begin
      out_valid_q <= 1'b0;
    end
  // per-source packet counters, free-running and wrapping
  always_ff @(posedge axis_aclk or negedge axis_resetn)
    if (!axis_resetn) begin
      cnt_agg_q <= '0;
      cnt_oq_q  <= '0;
    end else begin
      if (acc_agg & s_axis_agg_tlast) cnt_agg_q <= cnt_agg_q + 32'd1;
      if (acc_oq & s_axis_OQ_tlast) cnt_oq_q <= cnt_oq_q + 32'd1;
    end
endmodule

// File: tb/tb_agg_oq_merge.sv
// tb_agg_oq_merge: scoreboard bench for the agg/OQ packet merger
module tb_agg_oq_merge;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;
  logic clk = 0;
  logic rst_n = 0;
  logic [DW-1:0] agg_tdata, oq_tdata, m_tdata;
  logic [KW-1:0] agg_tkeep, oq_tkeep, m_tkeep;
  logic [UW-1:0] agg_tuser, oq_tuser, m_tuser;
  logic agg_tvalid, agg_tlast, agg_tready;
  logic oq_tvalid, oq_tlast, oq_tready;
  logic m_tlast, m_tvalid, m_tready;
  logic [31:0] cnt_agg, cnt_oq;
  logic [31:0] exp_agg, exp_oq;
  beat_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit sb_on = 1;
  bit agg_only = 0;
  bit bp = 0;
  logic [3:0] pat = 4'b1001;
  int k = 0;
  always #5 clk = ~clk;
  agg_oq_merge dut (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_agg_tdata(agg_tdata), .s_axis_agg_tkeep(agg_tkeep), .s_axis_agg_tuser(agg_tuser),
    .s_axis_agg_tvalid(agg_tvalid), .s_axis_agg_tlast(agg_tlast), .s_axis_agg_tready(agg_tready),
    .s_axis_OQ_tdata(oq_tdata), .s_axis_OQ_tkeep(oq_tkeep), .s_axis_OQ_tuser(oq_tuser),
    .s_axis_OQ_tvalid(oq_tvalid), .s_axis_OQ_tlast(oq_tlast), .s_axis_OQ_tready(oq_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .pkt_count_agg(cnt_agg), .pkt_count_OQ(cnt_oq)
  );
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic beat_t mk(input bit src, input int pid, input int b, input int n);
    beat_t r;
    logic [31:0] w;
    w = {src ? 8'hB0 : 8'hA0, pid[11:0], b[11:0]};
    r.d = {8{w}};
    r.k = w ^ 32'h5a5a_0f0f;
    r.u = {4{~w}};
    r.l = (b == n - 1);
    return r;
  endfunction
  task automatic push_pkt(input bit src, input int pid, input int n);
    for (int b = 0; b < n; b++) q.push_back(mk(src, pid, b, n));
    if (src) exp_oq = exp_oq + 32'd1;
    else exp_agg = exp_agg + 32'd1;
  endtask
  // drivers are entered right after a falling edge and return right after one
  task automatic send_agg(input int pid, input int n);
    for (int b = 0; b < n; b++) begin
      beat_t x;
      bit acc;
      int t;
      x = mk(0, pid, b, n);
      agg_tdata = x.d; agg_tkeep = x.k; agg_tuser = x.u; agg_tlast = x.l; agg_tvalid = 1;
      acc = 0;
      t = 0;
      while (!acc) begin
        #1 acc = agg_tvalid & agg_tready;
        @(negedge clk);
        t++;
        if (!acc && t > 200) begin
          check("agg accept timeout", 0, 1);
          agg_tvalid = 0;
          return;
        end
      end
    end
    agg_tvalid = 0;
  endtask
  task automatic send_oq(input int pid, input int n);
    for (int b = 0; b < n; b++) begin
      beat_t x;
      bit acc;
      int t;
      x = mk(1, pid, b, n);
      oq_tdata = x.d; oq_tkeep = x.k; oq_tuser = x.u; oq_tlast = x.l; oq_tvalid = 1;
      acc = 0;
      t = 0;
      while (!acc) begin
        #1 acc = oq_tvalid & oq_tready;
        @(negedge clk);
        t++;
        if (!acc && t > 200) begin
          check("OQ accept timeout", 0, 1);
          oq_tvalid = 0;
          return;
        end
      end
    end
    oq_tvalid = 0;
  endtask
  task automatic wait_drain();
    int t = 0;
    while ((q.size() != 0 || m_tvalid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("drain timeout", 0, 1);
    #2;
    check("cnt agg", cnt_agg, exp_agg);
    check("cnt OQ", cnt_oq, exp_oq);
  endtask
  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    q.delete();
    exp_agg = 0;
    exp_oq = 0;
  endtask
  // downstream ready: constant 1, or the 1,0,0,1 pattern when backpressure is on
  always begin
    @(negedge clk);
    m_tready = bp ? pat[k] : 1'b1;
    k = (k + 1) % 4;
  end
  // output monitor: scoreboard pops on handshake, stall and exclusivity rules every cycle
  always begin
    @(negedge clk);
    #2;
    if (rst_n && sb_on) begin
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) check("unexpected beat", 1, 0);
        else begin
          beat_t e;
          e = q.pop_front();
          check("tdata", m_tdata, e.d);
          check("tkeep", m_tkeep, e.k);
          check("tuser", m_tuser, e.u);
          check("tlast", m_tlast, e.l);
        end
      end
      if (m_tvalid && !m_tready) begin
        check("stall treadys", {agg_tready, oq_tready}, 0);
        if (q.size() != 0) check("stall hold tdata", m_tdata, q[0].d);
      end
      check("both treadys", agg_tready & oq_tready, 0);
      if (agg_only) check("OQ tready idle", oq_tready, 0);
    end
  end
  initial begin
    #200000;
    $display("FAIL global timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $finish;
  end
  initial begin
    agg_tdata = 0; agg_tkeep = 0; agg_tuser = 0; agg_tvalid = 0; agg_tlast = 0;
    oq_tdata = 0; oq_tkeep = 0; oq_tuser = 0; oq_tvalid = 0; oq_tlast = 0;
    m_tready = 1;
    exp_agg = 0;
    exp_oq = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst tvalid", m_tvalid, 0);
    check("rst tlast", m_tlast, 0);
    check("rst tdata", m_tdata, 0);
    check("rst treadys", {agg_tready, oq_tready}, 0);
    check("rst counts", {cnt_agg, cnt_oq}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    agg_only = 1;
    push_pkt(0, 1, 3);
    fork
      send_agg(1, 3);
      begin
        @(negedge clk);
        #2 check("lat arbitration", m_tvalid, 0);
        @(negedge clk);
        #2 check("lat first beat", m_tvalid, 1);
        repeat (2) begin
          @(negedge clk);
          #2 check("steady beat", m_tvalid, 1);
        end
        check("tlast beat3", m_tlast, 1);
      end
    join
    wait_drain();
    agg_only = 0;
    @(negedge clk);
    do_reset();
    push_pkt(0, 2, 2);
    push_pkt(1, 3, 2);
    fork
      send_agg(2, 2);
      send_oq(3, 2);
    join
    wait_drain();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 10 + i, 1);
      push_pkt(1, 20 + i, 1);
    end
    fork
      for (int i = 0; i < 4; i++) send_agg(10 + i, 1);
      for (int j = 0; j < 4; j++) send_oq(20 + j, 1);
    join
    wait_drain();
    @(negedge clk);
    bp = 1;
    push_pkt(1, 30, 4);
    send_oq(30, 4);
    wait_drain();
    bp = 0;
    @(negedge clk);
    @(negedge clk);
    sb_on = 0;
    begin
      beat_t x;
      x = mk(0, 40, 0, 4);
      agg_tdata = x.d; agg_tkeep = x.k; agg_tuser = x.u; agg_tlast = 0; agg_tvalid = 1;
      @(negedge clk);
      @(negedge clk);
      x = mk(0, 40, 1, 4);
      agg_tdata = x.d; agg_tkeep = x.k; agg_tuser = x.u;
      @(negedge clk);
      x = mk(0, 40, 2, 4);
      agg_tdata = x.d; agg_tkeep = x.k; agg_tuser = x.u;
      #3 check("pre-reset tvalid", m_tvalid, 1);
      rst_n = 0;
      #1;
      check("async rst tvalid", m_tvalid, 0);
      check("async rst tready", agg_tready, 0);
      check("async rst counts", {cnt_agg, cnt_oq}, 0);
      agg_tvalid = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    q.delete();
    exp_agg = 0;
    exp_oq = 0;
    sb_on = 1;
    push_pkt(0, 41, 2);
    send_agg(41, 2);
    wait_drain();
    @(negedge clk);
    force dut.cnt_agg_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_agg_q;
    #1 check("forced count", cnt_agg, 32'hFFFF_FFFF);
    exp_agg = 32'hFFFF_FFFF;
    @(negedge clk);
    push_pkt(0, 50, 1);
    send_agg(50, 1);
    wait_drain();
    check("wrapped count", cnt_agg, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
